// File: rtl/rp_asg_dac_cond.sv
// rp_asg_dac_cond: gain/offset/saturation conditioning of generator samples ahead of the DAC, with tail-hold / idle-level control
//   dac_clk_i, dac_rst_i        : clock, asynchronous active-high reset
//   dat_i, dat_stb_i, last_i    : generator sample, new-sample strobe, end-of-burst pulse
//   run_i                       : generator readout enabled
//   set_gain_i (Q2.14), set_offset_i, set_idle_i, set_tail_i : runtime settings
//   clr_i                       : synchronous clear of clip_cnt_o
//   dac_o, state_o, clip_cnt_o  : conditioned sample, FSM state, clipped-sample count
module rp_asg_dac_cond #(
    parameter int DW = 14,
    parameter int GW = 16,
    parameter int CW = 16
) (
    input  logic          dac_clk_i,
    input  logic          dac_rst_i,
    input  logic [DW-1:0] dat_i,
    input  logic          dat_stb_i,
    input  logic          last_i,
    input  logic          run_i,
    input  logic [GW-1:0] set_gain_i,
    input  logic [DW-1:0] set_offset_i,
    input  logic [DW-1:0] set_idle_i,
    input  logic [CW-1:0] set_tail_i,
    input  logic          clr_i,
    output logic [DW-1:0] dac_o,
    output logic [1:0]    state_o,
    output logic [CW-1:0] clip_cnt_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, TAIL = 2'd2} state_t;

    localparam logic signed [DW+2:0] SMAX = (DW+3)'(2 ** (DW - 1) - 1);
    localparam logic signed [DW+2:0] SMIN = -SMAX - 1;

    state_t                   st, st_d1, st_d2;
    logic [CW-1:0]            tail_cnt;
    logic signed [DW-1:0]     smp;
    logic signed [DW+GW-1:0]  p;
    logic signed [DW+2:0]     s;
    logic [2:0]               ld_d;
    logic                     ld, clip;
    logic signed [DW-1:0]     sat;

    // A strobe is taken while running or when it is the one that starts/retriggers a burst
    assign ld      = dat_stb_i && (st == RUN || run_i);
    assign state_o = st;

    always_comb begin
        clip = (s > SMAX) || (s < SMIN);
        sat  = clip ? (s < 0 ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}) : s[DW-1:0];
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            st       <= IDLE;
            tail_cnt <= '0;
        end else begin
            case (st)
                IDLE: if (dat_stb_i && run_i) st <= RUN;
                RUN: begin
                    if (last_i) begin
                        st       <= TAIL;
                        tail_cnt <= set_tail_i;
                    end else if (!run_i) begin
                        st <= IDLE;
                    end
                end
                TAIL: begin
                    if (dat_stb_i && run_i) begin
                        st       <= RUN;
                        tail_cnt <= '0;
                    end else begin
                        // leave when the decremented count hits zero (or was already zero)
                        tail_cnt <= (tail_cnt == '0) ? '0 : tail_cnt - 1'b1;
                        if (tail_cnt <= CW'(1)) st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
        if (dac_rst_i) begin
            smp        <= '0;
            p          <= '0;
            s          <= '0;
            st_d1      <= IDLE;
            st_d2      <= IDLE;
            ld_d       <= '0;
            dac_o      <= '0;
            clip_cnt_o <= '0;
        end else begin
            if (ld) smp <= dat_i;
            p     <= (DW+GW)'(smp) * (DW+GW)'($signed(set_gain_i));
            // arithmetic shift floors toward -inf; the scaled value always fits DW+2 bits
            s     <= (DW+3)'(p >>> (GW - 2)) + (DW+3)'($signed(set_offset_i));
            // state is already registered, so two delays line it up with the stage-3 result
            st_d1 <= st;
            st_d2 <= st_d1;
            // the strobe is combinational, so it needs three delays to reach stage 3
            ld_d  <= {ld_d[1:0], ld};
            dac_o <= (st_d2 == IDLE) ? set_idle_i : sat;
            clip_cnt_o <= clr_i ? '0 :
                          (ld_d[2] && clip && !(&clip_cnt_o)) ? clip_cnt_o + 1'b1 : clip_cnt_o;
        end
    end
endmodule

// File: tb/tb_rp_asg_dac_cond.sv
// tb_rp_asg_dac_cond: directed scoreboard bench for rp_asg_dac_cond
module tb_rp_asg_dac_cond;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] dat = '0;
  logic        stb = 1'b0, last = 1'b0, run = 1'b0, clr = 1'b0;
  logic [15:0] gain = 16'h4000;
  logic [13:0] offset = '0;
  logic [13:0] idle = 14'h100;
  logic [15:0] tail = 16'd4;
  logic [13:0] dac;
  logic [1:0]  state;
  logic [15:0] clip_cnt;
  rp_asg_dac_cond dut (
    .dac_clk_i(clk), .dac_rst_i(rst), .dat_i(dat), .dat_stb_i(stb),
    .last_i(last), .run_i(run), .set_gain_i(gain), .set_offset_i(offset),
    .set_idle_i(idle), .set_tail_i(tail), .clr_i(clr),
    .dac_o(dac), .state_o(state), .clip_cnt_o(clip_cnt)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  typedef struct {int c; int k; int v; int t;} exp_t;
  exp_t q[$];
  int checks = 0, fails = 0, tag = 0;
  function automatic string kname(input int k);
    return k == 0 ? "dac_o" : k == 1 ? "state_o" : "clip_cnt_o";
  endfunction
  task automatic expect_at(input int c, input int k, input int v);
    q.push_back('{c, k, v, tag});
    tag++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].c == cyc) begin
        int a;
        a = q[i].k == 0 ? int'($signed(dac)) : q[i].k == 1 ? int'(state) : int'(clip_cnt);
        checks++;
        if (a != q[i].v) begin
          fails++;
          $display("FAIL %s#%0d after edge %0d: got %0d, expected %0d", kname(q[i].k), q[i].t, cyc, a, q[i].v);
        end
        q.delete(i);
      end
    end
  end
  initial begin
    int n;
    expect_at(1, 0, 0);
    expect_at(1, 1, 0);
    expect_at(1, 2, 0);
    step(); step();
    rst = 1'b0;
    expect_at(4, 1, 0);
    expect_at(5, 0, 256);
    repeat (3) step();
    run = 1'b1; stb = 1'b1; dat = 14'd1000; n = cyc + 1;
    expect_at(n, 1, 1);
    expect_at(n + 2, 0, 256);
    expect_at(n + 3, 0, 1000);
    step(); stb = 1'b0;
    repeat (4) step();
    gain = 16'h7FFF; stb = 1'b1; dat = 14'd5000; n = cyc + 1;
    expect_at(n + 3, 0, 8191);
    expect_at(n + 3, 2, 1);
    expect_at(n + 5, 2, 1);
    step(); stb = 1'b0;
    repeat (5) step();
    clr = 1'b1;
    expect_at(cyc + 1, 2, 0);
    step(); clr = 1'b0;
    gain = 16'h4000; offset = 14'(-100); stb = 1'b1; dat = 14'(-8192); n = cyc + 1;
    expect_at(n + 3, 0, -8192);
    expect_at(n + 3, 2, 1);
    step(); stb = 1'b0;
    repeat (4) step();
    gain = 16'h2000; stb = 1'b1; dat = 14'(-1); n = cyc + 1;
    expect_at(n + 3, 0, -101);
    expect_at(n + 3, 2, 1);
    step(); stb = 1'b0;
    repeat (4) step();
    gain = 16'h4000; offset = '0; tail = 16'd4; stb = 1'b1; last = 1'b1; dat = 14'd500; n = cyc + 1;
    expect_at(cyc, 1, 1);
    for (int i = 0; i < 4; i++) expect_at(n + i, 1, 2);
    expect_at(n + 4, 1, 0);
    expect_at(n + 3, 0, 500);
    expect_at(n + 6, 0, 500);
    expect_at(n + 7, 0, 256);
    step(); stb = 1'b0; last = 1'b0; run = 1'b0;
    repeat (8) step();
    run = 1'b1; stb = 1'b1; dat = 14'd300; n = cyc + 1;
    step(); stb = 1'b0;
    step(); last = 1'b1;
    step(); last = 1'b0;
    step();
    expect_at(cyc, 1, 2);
    stb = 1'b1; dat = 14'd200;
    expect_at(n + 4, 1, 1);
    expect_at(n + 5, 1, 1);
    expect_at(n + 5, 0, 300);
    expect_at(n + 6, 0, 300);
    expect_at(n + 7, 0, 200);
    step(); stb = 1'b0;
    repeat (4) step();
    run = 1'b0; n = cyc + 1;
    expect_at(n, 1, 0);
    expect_at(n + 2, 0, 200);
    expect_at(n + 3, 0, 256);
    step();
    stb = 1'b1; last = 1'b1; dat = 14'd777;
    expect_at(cyc + 1, 1, 0);
    step(); stb = 1'b0; last = 1'b0;
    repeat (4) step();
    tail = '0; run = 1'b1; stb = 1'b1; last = 1'b1; dat = 14'd400; n = cyc + 1;
    expect_at(n, 1, 1);
    step(); stb = 1'b0;
    expect_at(n + 1, 1, 2);
    expect_at(n + 2, 1, 0);
    step(); last = 1'b0; run = 1'b0;
    repeat (5) step();
    run = 1'b1; stb = 1'b1; dat = 14'd600; n = cyc + 1;
    expect_at(n + 2, 1, 1);
    expect_at(n + 2, 2, 1);
    step(); stb = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    expect_at(cyc, 0, 0);
    expect_at(cyc, 1, 0);
    expect_at(cyc, 2, 0);
    #1;
    checks += 3;
    if (dac !== 14'd0) begin
      fails++;
      $display("FAIL async reset dac_o: got %0d", $signed(dac));
    end
    if (state !== 2'd0) begin
      fails++;
      $display("FAIL async reset state_o: got %0d", state);
    end
    if (clip_cnt !== 16'd0) begin
      fails++;
      $display("FAIL async reset clip_cnt_o: got %0d", clip_cnt);
    end
    step(); step();
    rst = 1'b0;
    gain = 16'h7FFF; stb = 1'b1; dat = 14'd5000;
    repeat (65545) step();
    expect_at(cyc, 2, 65535);
    checks++;
    if (clip_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL saturation clip_cnt_o: got %0d", clip_cnt);
    end
    clr = 1'b1;
    expect_at(cyc + 1, 2, 0);
    expect_at(cyc + 2, 2, 1);
    step(); clr = 1'b0;
    step(); step();
    stb = 1'b0; run = 1'b0;
    repeat (5) step();
    foreach (q[i]) begin
      checks++;
      fails++;
      $display("FAIL %s#%0d never reached: expected %0d", kname(q[i].k), q[i].t, q[i].v);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
